// File: rtl/ntt_bram_sequencer.sv
// Sequences one NTT job over a shared BRAM port: loads x from BRAM, runs the
// core, stores y back. Outputs are decoded combinationally from registered state.
module ntt_bram_sequencer #(
  parameter int N          = 64,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 12,
  parameter int SRC_BASE   = 0,
  parameter int DST_BASE   = 64,
  parameter int ADDR_SHIFT = 3,
  parameter int RD_LAT     = 1,
  parameter int TIMEOUT    = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_W-1:0]    bram_addr,
  output logic                 bram_en,
  output logic                 bram_we,
  output logic [DATA_W-1:0]    bram_din,
  input  logic [DATA_W-1:0]    bram_dout,
  output logic                 ntt_rst,
  input  logic                 ntt_done,
  output logic                 ntt_x_we,
  output logic [$clog2(N)-1:0] ntt_x_idx,
  output logic [DATA_W-1:0]    ntt_x_data,
  output logic [$clog2(N)-1:0] ntt_y_idx,
  input  logic [DATA_W-1:0]    ntt_y_data
);
  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, STORE, FINISH} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [TW-1:0]              tmr_q, tmr_d;
  logic                       error_q, error_d;
  logic [RD_LAT-1:0]          pv_q, pv_d;
  logic [RD_LAT-1:0][IW-1:0]  pi_q, pi_d;

  logic              issue, cap;
  logic [IW-1:0]     cap_idx;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  assign issue   = (state_q == LOAD) && (cnt_q < CW'(N));
  // read-return tracking: the issue index rides an RD_LAT-deep pipe to meet its data
  assign cap     = (state_q == LOAD) && pv_q[RD_LAT-1];
  assign cap_idx = pi_q[RD_LAT-1];
  assign rd_addr = ADDR_W'((SRC_BASE + 32'(cnt_q)) << ADDR_SHIFT);
  assign wr_addr = ADDR_W'((DST_BASE + 32'(cnt_q)) << ADDR_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      error_q <= 1'b0;
      pv_q    <= '0;
      pi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      error_q <= error_d;
      pv_q    <= pv_d;
      pi_q    <= pi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    error_d = error_q;
    pv_d    = '0;
    pi_d    = pi_q;
    if (state_q == LOAD) begin
      pv_d[0] = issue;
      pi_d[0] = cnt_q[IW-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        pv_d[i] = pv_q[i-1];
        pi_d[i] = pi_q[i-1];
      end
    end
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tmr_d = '0;
        if (start) begin
          state_d = LOAD;
          error_d = 1'b0;
        end
      end
      LOAD: begin
        if (issue) cnt_d = cnt_q + 1'b1;
        if (cap && cap_idx == IW'(N - 1)) begin
          state_d = COMPUTE;
          cnt_d   = '0;
          tmr_d   = '0;
        end
      end
      COMPUTE: begin
        if (ntt_done) begin
          state_d = STORE;
          cnt_d   = '0;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      STORE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rst gates the outputs so a mid-job reset kills the write in the same cycle
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_din   = '0;
    ntt_rst    = 1'b1;
    ntt_x_we   = 1'b0;
    ntt_x_idx  = '0;
    ntt_x_data = '0;
    ntt_y_idx  = '0;
    if (!rst) begin
      busy  = (state_q != IDLE);
      error = error_q;
      case (state_q)
        LOAD: begin
          bram_en  = issue;
          ntt_x_we = cap;
          if (issue) bram_addr = rd_addr;
          if (cap) begin
            ntt_x_idx  = cap_idx;
            ntt_x_data = bram_dout;
          end
        end
        COMPUTE: ntt_rst = 1'b0;
        STORE: begin
          ntt_rst   = 1'b0;
          bram_en   = 1'b1;
          bram_we   = 1'b1;
          bram_addr = wr_addr;
          ntt_y_idx = cnt_q[IW-1:0];
          bram_din  = ntt_y_data;
        end
        FINISH:  done = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_bram_sequencer.sv
// Two sequencers (RD_LAT 1 and 2) share a BRAM model; each job is checked
// against the expected read/capture/write streams and cycle counts.
module tb_ntt_bram_sequencer;
  localparam int N = 64, DW = 64, AW = 12, IW = 6, TO = 100, DST = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, start2;
  logic busy1, done1, error1, en1, we1, nrst1, ndone1, xwe1;
  logic busy2, done2, error2, en2, we2, nrst2, ndone2, xwe2;
  logic [AW-1:0] addr1, addr2;
  logic [DW-1:0] din1, din2, dout1, xdata1, xdata2, ydata1, ydata2;
  logic [IW-1:0] xidx1, xidx2, yidx1, yidx2;

  ntt_bram_sequencer #(.RD_LAT(1), .TIMEOUT(TO)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .error(error1),
    .bram_addr(addr1), .bram_en(en1), .bram_we(we1), .bram_din(din1), .bram_dout(dout1),
    .ntt_rst(nrst1), .ntt_done(ndone1), .ntt_x_we(xwe1), .ntt_x_idx(xidx1),
    .ntt_x_data(xdata1), .ntt_y_idx(yidx1), .ntt_y_data(ydata1));

  logic [DW-1:0] rd2a, rd2b;
  ntt_bram_sequencer #(.RD_LAT(2), .TIMEOUT(TO)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .error(error2),
    .bram_addr(addr2), .bram_en(en2), .bram_we(we2), .bram_din(din2), .bram_dout(rd2b),
    .ntt_rst(nrst2), .ntt_done(ndone2), .ntt_x_we(xwe2), .ntt_x_idx(xidx2),
    .ntt_x_data(xdata2), .ntt_y_idx(yidx2), .ntt_y_data(ydata2));

  // BRAM model with a testbench write port for preloading
  logic [DW-1:0] mem [512];
  logic          tb_we;
  logic [8:0]    tb_wa;
  logic [DW-1:0] tb_wd;
  always @(posedge clk) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    if (en1 && we1) mem[addr1[AW-1:3]] <= din1;
    if (en2 && we2) mem[addr2[AW-1:3]] <= din2;
    if (en1 && !we1) dout1 <= mem[addr1[AW-1:3]];
    if (en2 && !we2) rd2a <= mem[addr2[AW-1:3]];
    rd2b <= rd2a;
  end

  // core model: done a fixed number of cycles after release, y[i] = ~i ^ key
  int unsigned   dly;
  logic          done_en;
  logic [DW-1:0] key;
  int unsigned   cc1, cc2;
  always @(posedge clk) begin
    cc1 <= nrst1 ? 0 : cc1 + 1;
    cc2 <= nrst2 ? 0 : cc2 + 1;
  end
  assign ndone1 = done_en && !nrst1 && (cc1 >= dly);
  assign ndone2 = done_en && !nrst2 && (cc2 >= dly);
  assign ydata1 = ~{58'b0, yidx1} ^ key;
  assign ydata2 = ~{58'b0, yidx2} ^ key;

  int sel;
  logic v_busy, v_done, v_error, v_en, v_we, v_nrst, v_xwe;
  logic [AW-1:0] v_addr;
  logic [DW-1:0] v_din, v_xdata;
  logic [IW-1:0] v_xidx;
  always_comb begin
    if (sel == 1) begin
      v_busy = busy2; v_done = done2; v_error = error2; v_en = en2; v_we = we2;
      v_nrst = nrst2; v_xwe = xwe2; v_addr = addr2; v_din = din2; v_xdata = xdata2; v_xidx = xidx2;
    end else begin
      v_busy = busy1; v_done = done1; v_error = error1; v_en = en1; v_we = we1;
      v_nrst = nrst1; v_xwe = xwe1; v_addr = addr1; v_din = din1; v_xdata = xdata1; v_xidx = xidx1;
    end
  end

  int checks = 0, errors = 0;
  logic [DW-1:0] exp_x [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] yexp(input int k);
    return ~64'(k) ^ key;
  endfunction

  task automatic fill(input bit pat);
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      tb_we = 1'b1;
      tb_wa = 9'(k);
      if (k < N) begin
        exp_x[k] = pat ? 64'(32'h1000 + k) : {$urandom, $urandom};
        tb_wd = exp_x[k];
      end else begin
        tb_wd = 64'hDEAD_0000_0000_0000 | 64'(k);
      end
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run_job(input int g, input int d, input bit en, input int rst_at, input bit pat);
    int ft, dt, et, stray, lat;
    int xi[$];
    logic [63:0] xd[$], wd[$];
    logic [AW-1:0] ra[$], wa[$];
    sel = g; dly = d; done_en = en; lat = g + 1;
    key = pat ? 64'd0 : {$urandom, $urandom};
    fill(pat);
    ft = -1; dt = -1; et = -1; stray = 0;
    @(negedge clk);
    if (g == 1) start2 = 1'b1; else start1 = 1'b1;
    for (int t = 1; t <= 400; t++) begin
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      if (t == 1) begin
        chk("start_busy", v_busy, 1);
        chk("start_err_clr", v_error, 0);
      end
      if (v_en && !v_we) ra.push_back(v_addr);
      if (v_en && v_we) begin
        if (ft < 0) stray++;
        if (rst_at >= 0 && wa.size() == rst_at) begin
          rst = 1'b1;
          #1;
          chk("midrst_we", v_we, 0);
          chk("midrst_en", v_en, 0);
          chk("midrst_nrst", v_nrst, 1);
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          #1;
          chk("midrst_busy", v_busy, 0);
          chk("midrst_last_wr", mem[DST + rst_at - 1], yexp(rst_at - 1));
          chk("midrst_no_wr", mem[DST + rst_at], 64'hDEAD_0000_0000_0000 | 64'(N + rst_at));
          return;
        end
        wa.push_back(v_addr);
        wd.push_back(v_din);
      end
      if (v_xwe) begin
        xi.push_back(int'(v_xidx));
        xd.push_back(v_xdata);
      end
      if (!v_nrst && ft < 0) ft = t;
      if (v_done) begin dt = t; break; end
      if (v_error) begin et = t; break; end
    end
    chk("x_cnt", xi.size(), N);
    chk("rd_cnt", ra.size(), N);
    for (int k = 0; k < N && k < xi.size(); k++) begin
      chk("x_idx", xi[k], k);
      chk("x_data", xd[k], exp_x[k]);
    end
    for (int k = 0; k < N && k < ra.size(); k++) chk("rd_addr", ra[k], 64'((k * 8) & 12'hFFF));
    chk("load_len", ft, N + lat + 1);
    chk("stray_wr", stray, 0);
    if (!en) begin
      chk("timeout_at", et, N + lat + TO + 1);
      chk("timeout_wr", wa.size(), 0);
      chk("timeout_busy", v_busy, 0);
      chk("timeout_nrst", v_nrst, 1);
      chk("timeout_nodone", dt, -1);
    end else begin
      chk("latency", dt, 1 + N + lat + (d + 1) + N);
      chk("wr_cnt", wa.size(), N);
      for (int k = 0; k < N && k < wa.size(); k++) begin
        chk("wr_addr", wa[k], 64'(((DST + k) * 8) & 12'hFFF));
        chk("wr_data", wd[k], yexp(k));
      end
      @(posedge clk);
      @(negedge clk);
      chk("post_done", v_done, 0);
      chk("post_busy", v_busy, 0);
      chk("post_err", v_error, 0);
      for (int k = 0; k < N; k++) chk("mem_y", mem[DST + k], yexp(k));
    end
  endtask

  task automatic spam();
    int dn, nw;
    sel = 0; dly = 10; done_en = 1'b1; key = {$urandom, $urandom};
    fill(1'b0);
    dn = 0; nw = 0;
    @(negedge clk);
    start1 = 1'b1;
    for (int t = 1; t <= 300; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (v_done) dn++;
      if (v_en && v_we) nw++;
    end
    start1 = 1'b0;
    chk("spam_done", dn, 2);
    chk("spam_wr", nw, 2 * N);
    for (int t = 0; t < 400 && v_busy; t++) @(negedge clk);
    chk("spam_drain", v_busy, 0);
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    sel = 0; dly = 0; done_en = 1'b0; key = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_nrst", nrst1, 1);
    chk("rst_en", en1, 0);
    chk("rst_we", we1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_xwe", xwe1, 0);
    chk("rst_busy2", busy2, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", busy1, 0);
      chk("idle_done", done1, 0);
      chk("idle_err", error1, 0);
      chk("idle_nrst", nrst1, 1);
    end
    run_job(0, 10, 1'b1, -1, 1'b1);
    run_job(0, 0, 1'b1, -1, 1'b0);
    repeat (2) run_job(0, int'($urandom_range(0, 30)), 1'b1, -1, 1'b0);
    run_job(0, 0, 1'b0, -1, 1'b0);
    run_job(0, int'($urandom_range(0, 30)), 1'b1, -1, 1'b0);
    spam();
    run_job(0, 5, 1'b1, 20, 1'b0);
    run_job(0, int'($urandom_range(0, 30)), 1'b1, -1, 1'b0);
    run_job(1, 10, 1'b1, -1, 1'b1);
    run_job(1, int'($urandom_range(0, 30)), 1'b1, -1, 1'b0);
    run_job(1, 0, 1'b0, -1, 1'b0);
    run_job(1, 3, 1'b1, 20, 1'b0);
    run_job(1, int'($urandom_range(0, 30)), 1'b1, -1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
